// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int BR_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int unsigned j;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr) + k) % NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// Optional start-timeout in WAIT_BUSY is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GUARD_CYCLES  = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [BR_W-1:0]             br_select_in,
    input  logic                        uart_tx_busy,
    output logic                        uart_enable,
    output logic [BYTE_W-1:0]           uart_tx_data,
    output logic [BR_W-1:0]             uart_br_select,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic                        timeout_err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (GUARD_CYCLES > START_TIMEOUT) ? GUARD_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    arb_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // Gated by rst_n so the handshake is dead while reset is held.
    assign req_ready = (state == ST_IDLE && rst_n) ? pick_grant : '0;

`ifdef UART_ARB_TIMEOUT_EN
    logic timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            cnt            <= '0;
            uart_enable    <= 1'b0;
            uart_tx_data   <= '0;
            uart_br_select <= '0;
            grant_id       <= '0;
            active         <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            uart_enable <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        uart_tx_data <= req_data[pick_idx*BYTE_W +: BYTE_W];
                        grant_id     <= pick_idx;
                        ptr          <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        uart_enable  <= 1'b1;
                        active       <= 1'b1;
                        state        <= ST_LAUNCH;
                    end else begin
                        uart_br_select <= br_select_in;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        if (GUARD_CYCLES == 0) begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end else begin
                            cnt   <= '0;
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (GUARD_CYCLES == 0) begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end else begin
                            cnt   <= '0;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
